spi_master_frame_rx: RTL
========================

Name: spi_master_frame_rx

Overview:
Parametrised single-clock SPI master that replaces the fixed clk_div/spi_miso/FIFO-output chain with one block.
- Generates SCLK and chip-select from m_clk.
- Supports all four CPOL/CPHA modes.
- Shifts a per-word transmit stream out on MOSI and assembles FRAME_WORDS received words into one frame register.
- Presents the frame to the host with a valid/ready handshake and a sticky overrun flag.

Parameters:
- DATA_W, 8: bits per SPI word, MSB first, >=2.
- FRAME_WORDS, 15: words per chip-select frame, >=1.
- HALF_DIV, 2: m_clk cycles per SCLK half-period, >=1.

Ports:
- m_clk  in  1  system clock; all logic is single-clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- cpol  in  1  clock polarity; latched at start.
- cpha  in  1  clock phase; latched at start.
- tx_word  in  DATA_W  next word to transmit; captured when tx_next pulses.
- tx_next  out  1  one-cycle pulse when tx_word is captured.
- busy  out  1  high from the cycle after an accepted start until frame_valid is asserted.
- spi_sclk  out  1  SPI clock.
- spi_cs_n  out  1  chip select, active low.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in; externally synchronised.
- frame_data  out  DATA_W*FRAME_WORDS  received frame; word 0 occupies the MSBs.
- frame_valid  out  1  frame available; held until frame_ready.
- frame_ready  in  1  host accepts the frame.
- overrun  out  1  sticky; a completed frame was dropped.

Behaviour:
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, tx_next=0, frame_valid=0, overrun=0, frame_data=0. Latched mode register = 0. FSM = IDLE.
- Reset mid-frame aborts immediately. No partial frame is kept.
- FSM states:
  - IDLE -> SETUP on start.
  - SETUP lasts HALF_DIV cycles -> XFER.
  - XFER lasts 2*HALF_DIV*DATA_W*FRAME_WORDS cycles -> HOLD.
  - HOLD lasts HALF_DIV cycles -> IDLE.
- Start acceptance (cycle 0 = start high in IDLE), effective at cycle 1:
  - cpol/cpha latched.
  - spi_cs_n=0, busy=1.
  - tx_word captured and tx_next pulses.
- SCLK idle level:
  - Outside XFER, spi_sclk equals the latched cpol.
  - After reset, spi_sclk idles at 0 until the first start.
- Bit timing in XFER:
  - A half-period counter toggles spi_sclk every HALF_DIV cycles, giving 2*DATA_W edges per word. Odd edges are leading, even edges are trailing.
  - spi_miso is registered on the m_clk edge at which spi_sclk toggles.
- CPHA=0:
  - MSB is driven on spi_mosi at cycle 1.
  - Sample on each leading edge; shift out the next bit on each trailing edge.
- CPHA=1:
  - Shift out on each leading edge; the MSB appears on the first leading edge.
  - Sample on each trailing edge.
- Word boundaries:
  - On the last trailing edge of word k, the assembled word is written to slot k.
  - If k < FRAME_WORDS-1, tx_word is captured in the same cycle (tx_next pulse) and its MSB goes out per the mode rule. There is no inter-word gap.
- Frame completion, at the first cycle after HOLD (cycle 1 + HALF_DIV*(2*DATA_W*FRAME_WORDS+2)): spi_cs_n=1, busy=0, FSM = IDLE.
  - If frame_valid=0, or frame_ready=1 in that cycle: frame_data is updated from the assembly buffer and frame_valid=1.
  - Otherwise the new frame is dropped, frame_data keeps the old frame, and overrun sets.
- frame_valid clears the cycle after frame_valid & frame_ready.
- overrun clears only on reset.
- start while busy is ignored.
- start in the completion cycle is accepted; the FSM is in IDLE.
- Frame width is DATA_W*FRAME_WORDS bits. Bit and word counters are sized as clog2 of their ranges and wrap only by explicit reload.

Decomposition:
- Package spi_pkg holds:
  - The state enum (IDLE, SETUP, XFER, HOLD).
  - A mode typedef {cpol, cpha}.
  - Localparams FRAME_W = DATA_W*FRAME_WORDS and CNT_W = $clog2(HALF_DIV+1).
- One sub-module, spi_sclk_gen: half-period counter, sclk toggle, leading/trailing edge strobes.
- FSM, shifters and frame buffer stay in the top.

Test Plan:
All scenarios use DATA_W=8, FRAME_WORDS=2, HALF_DIV=2.
- Mode 0: start at cycle 0, slave returns 0xA5 then 0x3C, tx_word=0x81 then 0x7E -> cs_n low at cycles 1..68, MOSI carries 10000001 01111110, frame_valid=1 at cycle 69, frame_data=0xA53C, tx_next pulses at cycles 1 and 35.
- Modes 1, 2, 3, same data -> identical frame_data=0xA53C; SCLK idles at cpol; sample edge (sampled-bit log) matches each mode.
- Overrun: frame_ready held 0 across two frames -> second completion sets overrun=1 while frame_data stays 0xA53C; frame_ready=1 then clears frame_valid next cycle.
- Back-to-back: frame_ready=1 at completion and start re-asserted in the completion cycle -> new frame is accepted, overrun stays 0.
- Reset at cycle 30 mid-XFER -> same cycle: cs_n=1, sclk=0, busy=0, frame_valid=0; next start completes normally at cycle +69.
- start pulsed at cycle 10 while busy -> ignored; exactly one frame and two tx_next pulses.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI frame receiver.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } mode_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_FRAME_WORDS = 15;
  localparam int DEF_HALF_DIV    = 2;

  localparam int FRAME_W = DEF_DATA_W * DEF_FRAME_WORDS;
  localparam int CNT_W   = $clog2(DEF_HALF_DIV + 1);

  // Width of a down-counter that must hold the value half_div.
  function automatic int cnt_width(input int half_div);
    return $clog2(half_div + 1);
  endfunction

  function automatic int frame_width(input int data_w, input int frame_words);
    return data_w * frame_words;
  endfunction

endpackage

// File: rtl/spi_master_frame_rx_sclk_gen.sv
// SCLK generator: half-period down-counter, SCLK toggle and edge strobes.
// Strobes are asserted in the m_clk cycle whose closing edge toggles SCLK.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int HALF_DIV = DEF_HALF_DIV
) (
  input  logic m_clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic load_lvl,
  input  logic idle_lvl,
  output logic sclk,
  output logic lead,
  output logic trail
);

  localparam int HC_W = cnt_width(HALF_DIV);
  localparam logic [HC_W-1:0] HC_RELOAD = HC_W'(HALF_DIV - 1);

  logic [HC_W-1:0] half_cnt;
  logic            tc;

  assign tc    = en && (half_cnt == '0);
  // Every word has an even number of edges, so an edge leaving the idle level is leading.
  assign lead  = tc && (sclk == idle_lvl);
  assign trail = tc && (sclk != idle_lvl);

  // Half-period counter reloads at terminal count and is parked while disabled; SCLK toggles at terminal count.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      half_cnt <= HC_RELOAD;
      sclk     <= 1'b0;
    end else begin
      if (!en || tc) half_cnt <= HC_RELOAD;
      else           half_cnt <= half_cnt - 1'b1;
      if (load)    sclk <= load_lvl;
      else if (tc) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_frame_rx.sv
// SPI master that clocks out a per-word transmit stream and assembles
// FRAME_WORDS received words into one frame offered via valid/ready.
//
// state | meaning
// IDLE  | chip select high, waiting for start
// SETUP | chip select low, HALF_DIV cycles before the first SCLK edge
// XFER  | SCLK running, 2*DATA_W edges per word, no inter-word gap
// HOLD  | HALF_DIV cycles after the last edge before chip select rises
module spi_master_frame_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int HALF_DIV    = DEF_HALF_DIV
) (
  input  logic                            m_clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            cpol,
  input  logic                            cpha,
  input  logic [DATA_W-1:0]               tx_word,
  output logic                            tx_next,
  output logic                            busy,
  output logic                            spi_sclk,
  output logic                            spi_cs_n,
  output logic                            spi_mosi,
  input  logic                            spi_miso,
  output logic [DATA_W*FRAME_WORDS-1:0]   frame_data,
  output logic                            frame_valid,
  input  logic                            frame_ready,
  output logic                            overrun
);

  localparam int FRM_W = frame_width(DATA_W, FRAME_WORDS);
  localparam int HC_W  = cnt_width(HALF_DIV);
  localparam int BIT_W = $clog2(2 * DATA_W);
  localparam int WRD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [HC_W-1:0]  PH_RELOAD = HC_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * DATA_W - 1);
  localparam logic [WRD_W-1:0] WRD_LAST  = WRD_W'(FRAME_WORDS - 1);

  state_t            state, state_nxt;
  mode_t             mode;
  logic [HC_W-1:0]   phase_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WRD_W-1:0]  word_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_word;
  logic [FRM_W-1:0]  asm_buf;
  logic              accept, lead, trail, sample_edge, shift_edge;
  logic              last_bit, last_word, word_end, frame_end, done;

  assign accept      = (state == IDLE) && start;
  assign sample_edge = mode.cpha ? trail : lead;
  assign shift_edge  = mode.cpha ? lead : trail;
  assign last_bit    = (bit_cnt == BIT_LAST);
  assign last_word   = (word_cnt == WRD_LAST);
  assign word_end    = trail && last_bit;
  assign frame_end   = word_end && last_word;
  assign done        = (state == HOLD) && (phase_cnt == '0);
  // With CPHA=1 the final bit is sampled on the same edge that closes the word.
  assign rx_word     = mode.cpha ? {rx_sh[DATA_W-2:0], spi_miso} : rx_sh;

  assign spi_cs_n = (state == IDLE);
  assign busy     = (state != IDLE);

  spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk_gen (
    .m_clk    (m_clk),
    .rst      (rst),
    .en       (state == XFER),
    .load     (accept),
    .load_lvl (cpol),
    .idle_lvl (mode.cpol),
    .sclk     (spi_sclk),
    .lead     (lead),
    .trail    (trail)
  );

  // State register.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)             state_nxt = SETUP;
      SETUP:   if (phase_cnt == '0)   state_nxt = XFER;
      XFER:    if (frame_end)         state_nxt = HOLD;
      HOLD:    if (phase_cnt == '0)   state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // SETUP/HOLD duration down-counter, reloaded on every state change.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst)                         phase_cnt <= PH_RELOAD;
    else if (state_nxt != state)     phase_cnt <= PH_RELOAD;
    else if (phase_cnt != '0)        phase_cnt <= phase_cnt - 1'b1;
  end

  // Mode latch, bit/word counters, transmit and receive shifters, assembly buffer.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      mode     <= '0;
      tx_next  <= 1'b0;
      spi_mosi <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      asm_buf  <= '0;
    end else begin
      tx_next <= 1'b0;
      if (accept) begin
        mode     <= '{cpol: cpol, cpha: cpha};
        tx_next  <= 1'b1;
        bit_cnt  <= '0;
        word_cnt <= '0;
        if (!cpha) begin
          spi_mosi <= tx_word[DATA_W-1];
          tx_sh    <= {tx_word[DATA_W-2:0], 1'b0};
        end else begin
          tx_sh    <= tx_word;
        end
      end else if (state == XFER) begin
        if (lead || trail) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        if (sample_edge) rx_sh <= {rx_sh[DATA_W-2:0], spi_miso};
        if (shift_edge && !word_end) begin
          spi_mosi <= tx_sh[DATA_W-1];
          tx_sh    <= {tx_sh[DATA_W-2:0], 1'b0};
        end
        if (word_end) begin
          asm_buf[FRM_W-1-int'(word_cnt)*DATA_W -: DATA_W] <= rx_word;
          if (!last_word) begin
            word_cnt <= word_cnt + 1'b1;
            tx_next  <= 1'b1;
            if (!mode.cpha) begin
              spi_mosi <= tx_word[DATA_W-1];
              tx_sh    <= {tx_word[DATA_W-2:0], 1'b0};
            end else begin
              tx_sh    <= tx_word;
            end
          end
        end
      end
    end
  end

  // Host-side frame register: publish on completion unless an unread frame is pending.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_valid && frame_ready) frame_valid <= 1'b0;
      if (done) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= asm_buf;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
